score_7seg_scan: RTL and testbench

Consumes the BCD hundreds/tens/ones digits produced by the score binary-to-BCD converter and drives the board's 4-digit common-anode seven-segment display by time-multiplexing. A refresh counter rotates one active digit at a time. Leading zeros are blanked. The BCD inputs are snapshotted once per full scan so a digit never changes partway through a frame. Sits between the score BCD converter and the top-level display pins.

---
 rtl/score_7seg_scan_pkg.sv | 40 ++++
 rtl/score_7seg_scan_if.sv | 18 +
 rtl/score_7seg_scan_bcd_to_7seg.sv | 26 ++
 rtl/score_7seg_scan.sv | 129 ++++++++++++
 tb/tb_score_7seg_scan.sv | 122 ++++++++++++
 5 files changed

// File: rtl/score_7seg_scan_pkg.sv
// rtl/score_7seg_scan_pkg.sv - shared segment/anode constants and slot indices for the score display scanner
package score_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [1:0] SLOT_ONES = 2'd0;
    localparam logic [1:0] SLOT_TENS = 2'd1;
    localparam logic [1:0] SLOT_HUND = 2'd2;
    localparam logic [1:0] SLOT_IDLE = 2'd3;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } bcd3_t;

    // Active-low anode pattern for a slot; the idle slot lights nothing.
    function automatic logic [3:0] an_for_slot(input logic [1:0] slot);
        case (slot)
            SLOT_ONES: an_for_slot = 4'b1110;
            SLOT_TENS: an_for_slot = 4'b1101;
            SLOT_HUND: an_for_slot = 4'b1011;
            default:   an_for_slot = AN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/score_7seg_scan_if.sv
// rtl/score_7seg_scan_if.sv - BCD digit inputs and display pin outputs of the scanner; blink under SCORE_BLINK_EN
interface score_7seg_scan_if;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
`ifdef SCORE_BLINK_EN
    logic       blink;

    modport master (output hundreds, tens, ones, blink, input an, seg, dp);
    modport slave  (input hundreds, tens, ones, blink, output an, seg, dp);
`else
    modport master (output hundreds, tens, ones, input an, seg, dp);
    modport slave  (input hundreds, tens, ones, output an, seg, dp);
`endif
endinterface

// File: rtl/score_7seg_scan_bcd_to_7seg.sv
// rtl/score_7seg_scan_bcd_to_7seg.sv - BCD digit to active-low segment pattern, dash for 10-15
module bcd_to_7seg
    import score_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_7seg_scan.sv
// rtl/score_7seg_scan.sv - time-multiplexed 4-digit score display with leading-zero blanking
// Optional blinking of the whole display is built when SCORE_BLINK_EN is defined.
module score_7seg_scan
    import score_disp_pkg::*;
#(
    parameter int REFRESH_CNT = 100000,
    parameter int CNT_W       = 17
`ifdef SCORE_BLINK_EN
   ,parameter int BLINK_CNT   = 25000000
`endif
)(
    input  logic            clk,
    input  logic            rst,
    score_7seg_scan_if.slave disp
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       slot_q, slot_d;
    bcd3_t            snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             wrap;
    logic [3:0]       digit;
    logic             blank;
    logic [6:0]       dec_seg;
    logic [3:0]       an_sel;

    bcd_to_7seg u_dec (
        .digit_i (digit),
        .seg_o   (dec_seg)
    );

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        slot_d = wrap ? slot_q + 2'd1 : slot_q;
        // Capture only at the frame boundary so a digit never changes mid-frame.
        snap_d = snap_q;
        if (wrap && slot_q == SLOT_IDLE) begin
            snap_d = '{h: disp.hundreds, t: disp.tens, o: disp.ones};
        end

        digit = snap_q.o;
        blank = 1'b0;
        case (slot_q)
            SLOT_ONES: begin
                digit = snap_q.o;
                blank = 1'b0;
            end
            SLOT_TENS: begin
                digit = snap_q.t;
                blank = (snap_q.h == 4'd0) && (snap_q.t == 4'd0);
            end
            SLOT_HUND: begin
                digit = snap_q.h;
                blank = (snap_q.h == 4'd0);
            end
            default: begin
                digit = 4'd0;
                blank = 1'b1;
            end
        endcase

        an_sel = blank ? AN_OFF : an_for_slot(slot_q);
        seg_d  = blank ? SEG_BLANK : dec_seg;
    end

`ifdef SCORE_BLINK_EN
    localparam int BW = $clog2(BLINK_CNT) + 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (disp.blink) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
        an_d = phase_q ? AN_OFF : an_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    always_comb begin
        an_d = an_sel;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            slot_q <= SLOT_ONES;
            snap_q <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = 1'b1;

endmodule

// File: tb/tb_score_7seg_scan.sv
// tb/tb_score_7seg_scan.sv - directed self-checking bench for score_7seg_scan with REFRESH_CNT=4
module tb_score_7seg_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    score_7seg_scan_if dif ();

    score_7seg_scan #(
        .REFRESH_CNT (4),
        .CNT_W       (3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_bcd(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        dif.hundreds = h;
        dif.tens     = t;
        dif.ones     = o;
    endtask

    task automatic check_slot(input string tag, input logic [3:0] an, input logic [6:0] seg);
        for (int c = 0; c < 4; c++) begin
            tick();
            check({tag, "_an"},  {28'd0, dif.an},  {28'd0, an});
            check({tag, "_seg"}, {25'd0, dif.seg}, {25'd0, seg});
            check({tag, "_dp"},  {31'd0, dif.dp},  32'd1);
        end
    endtask

    task automatic check_frame(input string tag,
                               input logic [3:0] an0, input logic [6:0] seg0,
                               input logic [3:0] an1, input logic [6:0] seg1,
                               input logic [3:0] an2, input logic [6:0] seg2);
        check_slot({tag, "_s0"}, an0, seg0);
        check_slot({tag, "_s1"}, an1, seg1);
        check_slot({tag, "_s2"}, an2, seg2);
        check_slot({tag, "_s3"}, 4'b1111, 7'b1111111);
    endtask

    initial begin
        set_bcd(4'd0, 4'd0, 4'd0);
`ifdef SCORE_BLINK_EN
        dif.blink = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) tick();
        check("rst_an",  {28'd0, dif.an},  32'hF);
        check("rst_seg", {25'd0, dif.seg}, 32'h7F);
        check("rst_dp",  {31'd0, dif.dp},  32'd1);

        // Frame 0 after reset shows the cleared snapshot; 123 is captured at its end.
        rst = 1'b0;
        set_bcd(4'd1, 4'd2, 4'd3);
        check_frame("f0_zero", 4'b1110, 7'b1000000, 4'b1111, 7'b1111111, 4'b1111, 7'b1111111);

        set_bcd(4'd0, 4'd0, 4'd7);
        check_frame("f1_123", 4'b1110, 7'b0110000, 4'b1101, 7'b0100100, 4'b1011, 7'b1111001);

        set_bcd(4'd1, 4'd0, 4'd5);
        check_frame("f2_007", 4'b1110, 7'b1111000, 4'b1111, 7'b1111111, 4'b1111, 7'b1111111);

        set_bcd(4'd0, 4'd0, 4'hB);
        check_frame("f3_105", 4'b1110, 7'b0010010, 4'b1101, 7'b1000000, 4'b1011, 7'b1111001);

        set_bcd(4'd1, 4'd2, 4'd3);
        check_frame("f4_dash", 4'b1110, 7'b0111111, 4'b1111, 7'b1111111, 4'b1111, 7'b1111111);

        // Inputs change to 456 inside slot 1; the rest of the frame keeps 123.
        check_slot("f5_s0", 4'b1110, 7'b0110000);
        tick();
        check("f5_s1a_an",  {28'd0, dif.an},  32'hD);
        check("f5_s1a_seg", {25'd0, dif.seg}, {25'd0, 7'b0100100});
        set_bcd(4'd4, 4'd5, 4'd6);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("f5_s1b_an",  {28'd0, dif.an},  32'hD);
            check("f5_s1b_seg", {25'd0, dif.seg}, {25'd0, 7'b0100100});
        end
        check_slot("f5_s2", 4'b1011, 7'b1111001);
        check_slot("f5_s3", 4'b1111, 7'b1111111);

        // Frame with 456, reset pulsed in slot 2.
        check_slot("f6_s0", 4'b1110, 7'b0000010);
        check_slot("f6_s1", 4'b1101, 7'b0010010);
        tick();
        check("f6_s2_an",  {28'd0, dif.an},  32'hB);
        check("f6_s2_seg", {25'd0, dif.seg}, {25'd0, 7'b0011001});
        rst = 1'b1;
        tick();
        check("midrst_an",  {28'd0, dif.an},  32'hF);
        check("midrst_seg", {25'd0, dif.seg}, 32'h7F);
        rst = 1'b0;

        check_frame("f7_cleared", 4'b1110, 7'b1000000, 4'b1111, 7'b1111111, 4'b1111, 7'b1111111);
        check_frame("f8_456", 4'b1110, 7'b0000010, 4'b1101, 7'b0010010, 4'b1011, 7'b0011001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
